// File: rtl/viterbi_channel_injector_pkg.sv
// Shared types and helpers for the Viterbi noisy-channel injector.
package viterbi_chan_pkg;

  typedef enum logic [1:0] {
    ModeBypass = 2'd0,
    ModeRandom = 2'd1,
    ModeBurst  = 2'd2,
    ModeFixed  = 2'd3
  } chan_mode_e;

  typedef enum logic {
    StIdle,
    StBurst
  } burst_st_e;

  // Galois toggle mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c += {5'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/viterbi_channel_injector_if.sv
// Symbol stream in/out of the channel injector.
interface viterbi_channel_injector_if #(
  parameter int unsigned W = 2
) ();
  logic         valid_i;
  logic [W-1:0] sym_i;
  logic         valid_o;
  logic [W-1:0] sym_o;
  logic [W-1:0] err_mask_o;

  // Master drives encoder symbols and observes the corrupted stream.
  modport master (
    output valid_i, sym_i,
    input  valid_o, sym_o, err_mask_o
  );

  // Slave is the injector itself.
  modport slave (
    input  valid_i, sym_i,
    output valid_o, sym_o, err_mask_o
  );
endinterface

// File: rtl/viterbi_channel_injector_lfsr.sv
// 32-bit Galois LFSR with synchronous reload; exposes the low OUT_W state bits.
module chan_lfsr
  import viterbi_chan_pkg::*;
#(
  parameter logic [31:0] RESET_VAL = 32'hACE1_0001,
  parameter int unsigned OUT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [31:0]      seed_i,
  input  logic             step_i,
  output logic [OUT_W-1:0] state_o
);

  logic [31:0] r_state;
  logic [31:0] w_next;

  // Next state: shift right, fold the taps in when a one falls out.
  always_comb begin
    w_next = r_state >> 1;
    if (r_state[0]) w_next = w_next ^ LFSR_TAPS;
  end

  // State register; reload has priority over stepping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RESET_VAL;
    end else if (load_i) begin
      r_state <= seed_i;
    end else if (step_i) begin
      r_state <= w_next;
    end
  end

  assign state_o = r_state[OUT_W-1:0];

endmodule

// File: rtl/viterbi_channel_injector.sv
// Noisy-channel model: registers each code symbol and XORs in an error mask drawn from one of
// four modes, counting symbols, errored symbols and flipped bits over an injection window.
module viterbi_channel_injector
  import viterbi_chan_pkg::*;
#(
  parameter int unsigned W         = 2,
  parameter int unsigned N         = 3,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned WINDOW    = 256,
  parameter int unsigned CW        = 16,
  parameter logic [31:0] SEED      = 32'hACE1_0001
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [1:0]                 mode_i,
  input  logic [W-1:0]               pattern_i,
  viterbi_channel_injector_if.slave  bus,
  output logic [CW-1:0]              sym_ct_o,
  output logic [CW-1:0]              err_sym_ct_o,
  output logic [CW-1:0]              err_bit_ct_o,
  output logic                       window_done_o
);

  localparam int unsigned RW         = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned CW1        = CW + 1;
  localparam int unsigned LFSR_OUT_W = N + W;
  localparam logic [CW-1:0] WINDOW_CT = CW'(WINDOW);
  localparam logic [CW-1:0] CT_MAX    = '1;
  localparam logic [RW-1:0] REM_INIT  = RW'(BURST_LEN - 1);
  localparam logic [RW-1:0] REM_ONE   = RW'(1);

  chan_mode_e              w_mode;
  logic                    w_accept;
  logic                    w_in_window;
  logic                    w_trig;
  logic [W-1:0]            w_mask;
  logic [LFSR_OUT_W-1:0]   w_lfsr;
  logic [5:0]              w_pop;
  logic [CW:0]             w_sym_sum;
  logic [CW:0]             w_es_sum;
  logic [CW:0]             w_eb_sum;

  burst_st_e               r_st;
  logic [RW-1:0]           r_rem;
  logic                    r_valid;
  logic [W-1:0]            r_sym;
  logic [W-1:0]            r_mask;
  logic [CW-1:0]           r_sym_ct;
  logic [CW-1:0]           r_err_sym_ct;
  logic [CW-1:0]           r_err_bit_ct;

  assign w_mode      = chan_mode_e'(mode_i);
  // start_i wins: a symbol arriving with it is dropped.
  assign w_accept    = bus.valid_i & ~start_i;
  // Symbol index k is the count before this symbol is added.
  assign w_in_window = r_sym_ct < WINDOW_CT;
  assign w_trig      = &w_lfsr[N-1:0];

  chan_lfsr #(
    .RESET_VAL (SEED),
    .OUT_W     (LFSR_OUT_W)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (start_i),
    .seed_i  (SEED),
    .step_i  (w_accept),
    .state_o (w_lfsr)
  );

  // Error mask for the symbol presented this cycle.
  always_comb begin
    w_mask = '0;
    if (w_in_window) begin
      unique case (w_mode)
        ModeBypass: w_mask = '0;
        ModeRandom: if (w_trig) w_mask = w_lfsr[N+W-1:N];
        ModeBurst:  if (r_st == StBurst || w_trig) w_mask = '1;
        ModeFixed:  if (r_sym_ct[N-1:0] == '0) w_mask = pattern_i;
        default:    w_mask = '0;
      endcase
    end
  end

  assign w_pop     = popcount(32'(w_mask));
  assign w_sym_sum = {1'b0, r_sym_ct} + CW1'(1);
  assign w_es_sum  = {1'b0, r_err_sym_ct} + CW1'(w_mask != '0);
  assign w_eb_sum  = {1'b0, r_err_bit_ct} + CW1'(w_pop);

  // Burst FSM; any non-burst symbol or out-of-window symbol aborts a burst in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st  <= StIdle;
      r_rem <= '0;
    end else if (start_i) begin
      r_st  <= StIdle;
      r_rem <= '0;
    end else if (w_accept) begin
      if (!w_in_window || w_mode != ModeBurst) begin
        r_st  <= StIdle;
        r_rem <= '0;
      end else if (r_st == StBurst) begin
        r_rem <= r_rem - REM_ONE;
        if (r_rem == REM_ONE) r_st <= StIdle;
      end else if (w_trig && BURST_LEN > 1) begin
        r_st  <= StBurst;
        r_rem <= REM_INIT;
      end
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sym_ct     <= '0;
      r_err_sym_ct <= '0;
      r_err_bit_ct <= '0;
    end else if (start_i) begin
      r_sym_ct     <= '0;
      r_err_sym_ct <= '0;
      r_err_bit_ct <= '0;
    end else if (w_accept) begin
      r_sym_ct     <= w_sym_sum[CW] ? CT_MAX : w_sym_sum[CW-1:0];
      r_err_sym_ct <= w_es_sum[CW]  ? CT_MAX : w_es_sum[CW-1:0];
      r_err_bit_ct <= w_eb_sum[CW]  ? CT_MAX : w_eb_sum[CW-1:0];
    end
  end

  // Output stage; symbol and mask hold their last values while no symbol is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_sym   <= '0;
      r_mask  <= '0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_sym  <= bus.sym_i ^ w_mask;
        r_mask <= w_mask;
      end
    end
  end

  assign bus.valid_o    = r_valid;
  assign bus.sym_o      = r_sym;
  assign bus.err_mask_o = r_mask;
  assign sym_ct_o       = r_sym_ct;
  assign err_sym_ct_o   = r_err_sym_ct;
  assign err_bit_ct_o   = r_err_bit_ct;
  assign window_done_o  = r_sym_ct >= WINDOW_CT;

endmodule

// File: tb/tb_viterbi_channel_injector.sv
// Bench for viterbi_channel_injector: table of whole-run vectors, a behavioural channel model
// checked per symbol, plus hand sequences for restart, reproducibility and mid-burst reset.
module tb_viterbi_channel_injector;

  localparam int unsigned W    = 2;
  localparam int unsigned N    = 3;
  localparam int unsigned BLEN = 4;
  localparam int          WIN  = 256;
  localparam int unsigned CW   = 16;
  localparam logic [31:0] SEED = 32'hACE1_0001;
  localparam int          NMAX = 512;

  logic           clk;
  logic           rst;
  logic           start_i;
  logic [1:0]     mode_i;
  logic [W-1:0]   pattern_i;
  logic [CW-1:0]  sym_ct_o;
  logic [CW-1:0]  err_sym_ct_o;
  logic [CW-1:0]  err_bit_ct_o;
  logic           window_done_o;

  viterbi_channel_injector_if #(.W(W)) bus ();

  viterbi_channel_injector #(
    .W         (W),
    .N         (N),
    .BURST_LEN (BLEN),
    .WINDOW    (WIN),
    .CW        (CW),
    .SEED      (SEED)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .mode_i        (mode_i),
    .pattern_i     (pattern_i),
    .bus           (bus),
    .sym_ct_o      (sym_ct_o),
    .err_sym_ct_o  (err_sym_ct_o),
    .err_bit_ct_o  (err_bit_ct_o),
    .window_done_o (window_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  // Channel model state.
  logic [31:0]  m_lfsr;
  int           m_k;
  int           m_es;
  int           m_eb;
  int           m_left;
  logic         m_valid;
  logic [W-1:0] m_sym;
  logic [W-1:0] m_mask;

  logic [W-1:0] data[NMAX];
  logic [W-1:0] rec[NMAX];
  logic [W-1:0] saved_burst[NMAX];
  logic [W-1:0] saved_rand[NMAX];

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] pat;
    int           n;
    int           e_sym;
    int           e_es;
    int           e_eb;
    logic         e_done;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_counts(input string name, input int e_sym, input int e_es, input int e_eb);
    check({name, "_sym_ct"}, 64'(sym_ct_o), 64'(e_sym));
    check({name, "_err_sym_ct"}, 64'(err_sym_ct_o), 64'(e_es));
    check({name, "_err_bit_ct"}, 64'(err_bit_ct_o), 64'(e_eb));
  endtask

  // Polynomial x^32+x^22+x^2+x+1 stepped in right-shifting Galois form.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    int          expo[4] = '{32, 22, 2, 1};
    logic [31:0] poly;
    poly = '0;
    foreach (expo[i]) poly[expo[i]-1] = 1'b1;
    return s[0] ? ((s >> 1) ^ poly) : (s >> 1);
  endfunction

  function automatic int sat(input int x);
    return (x > 65535) ? 65535 : x;
  endfunction

  task automatic model_clear(input bit hard);
    m_lfsr  = SEED;
    m_k     = 0;
    m_es    = 0;
    m_eb    = 0;
    m_left  = 0;
    m_valid = 1'b0;
    if (hard) begin
      m_sym  = '0;
      m_mask = '0;
    end
  endtask

  task automatic model_accept(input logic [W-1:0] s);
    logic [W-1:0] mask;
    logic [31:0]  low;
    bit           trig;
    mask = '0;
    low  = (32'd1 << N) - 32'd1;
    trig = (m_lfsr & low) == low;
    if (m_k < WIN) begin
      case (mode_i)
        2'd1: if (trig) mask = W'(m_lfsr >> N);
        2'd2: begin
          if (m_left > 0) begin
            mask = '1;
            m_left--;
          end else if (trig) begin
            mask   = '1;
            m_left = int'(BLEN) - 1;
          end
        end
        2'd3: if ((m_k % (1 << N)) == 0) mask = pattern_i;
        default: mask = '0;
      endcase
    end
    if (m_k >= WIN || mode_i != 2'd2) m_left = 0;
    m_lfsr = lfsr_next(m_lfsr);
    m_k    = sat(m_k + 1);
    if (mask != '0) m_es = sat(m_es + 1);
    m_eb    = sat(m_eb + $countones(mask));
    m_valid = 1'b1;
    m_sym   = s ^ mask;
    m_mask  = mask;
  endtask

  // One clock of stimulus, then compare the registered outputs against the model.
  task automatic send(input logic v, input logic st, input logic [W-1:0] s);
    @(negedge clk);
    bus.valid_i = v;
    bus.sym_i   = s;
    start_i     = st;
    @(posedge clk);
    #1;
    if (st) model_clear(1'b0);
    else if (v) model_accept(s);
    else m_valid = 1'b0;
    check($sformatf("out_k%0d", m_k), 64'({bus.valid_o, bus.sym_o, bus.err_mask_o}),
          64'({m_valid, m_sym, m_mask}));
    check("window_done", 64'(window_done_o), 64'(m_k >= WIN));
    bus.valid_i = 1'b0;
    start_i     = 1'b0;
  endtask

  task automatic run(input logic [1:0] mode, input logic [W-1:0] pat, input int n,
                     input bit gaps, input bit do_start);
    mode_i    = mode;
    pattern_i = pat;
    if (do_start) send(1'b1, 1'b1, data[0]);
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(3) == 0)) send(1'b0, 1'b0, W'($urandom));
      send(1'b1, 1'b0, data[i % NMAX]);
      rec[i % NMAX] = bus.sym_o;
    end
  endtask

  initial begin
    int b_es, b_eb, r_es, r_eb, mism, guard;

    vecs[0] = '{2'd0, 2'b00, 300, 300, 0, 0, 1'b1};
    vecs[1] = '{2'd3, 2'b01, 256, 256, 32, 32, 1'b1};
    vecs[2] = '{2'd3, 2'b11, 300, 300, 32, 64, 1'b1};
    vecs[3] = '{2'd3, 2'b10, 100, 100, 13, 13, 1'b0};
    vecs[4] = '{2'd0, 2'b00, 255, 255, 0, 0, 1'b0};
    foreach (data[i]) data[i] = W'($urandom);

    rst         = 1'b1;
    start_i     = 1'b0;
    mode_i      = 2'd0;
    pattern_i   = '0;
    bus.valid_i = 1'b0;
    bus.sym_i   = '0;
    model_clear(1'b1);
    #2;
    check("reset_out", 64'({bus.valid_o, bus.sym_o, bus.err_mask_o}), 64'(0));
    check_counts("reset", 0, 0, 0);
    check("reset_done", 64'(window_done_o), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Whole-run vectors with random valid gaps.
    for (int t = 0; t < 5; t++) begin
      run(vecs[t].mode, vecs[t].pat, vecs[t].n, 1'b1, 1'b1);
      check_counts($sformatf("vec%0d", t), vecs[t].e_sym, vecs[t].e_es, vecs[t].e_eb);
      check($sformatf("vec%0d_done", t), 64'(window_done_o), 64'(vecs[t].e_done));
    end
    // 256th symbol raises window_done.
    send(1'b1, 1'b0, data[1]);
    check("done_at_256", 64'(window_done_o), 64'(1));

    // Burst run from SEED, exact counts from the model.
    run(2'd2, '0, 300, 1'b0, 1'b1);
    check_counts("burst", m_k, m_es, m_eb);
    check("burst_bits_2x", 64'(err_bit_ct_o), 64'(2 * int'(err_sym_ct_o)));
    b_es        = m_es;
    b_eb        = m_eb;
    saved_burst = rec;

    // Random mode twice from a restart must reproduce.
    run(2'd1, '0, 256, 1'b1, 1'b1);
    check_counts("rand1", 256, m_es, m_eb);
    r_es       = m_es;
    r_eb       = m_eb;
    saved_rand = rec;
    send(1'b1, 1'b1, data[3]);
    check("start_drop_valid", 64'(bus.valid_o), 64'(0));
    check_counts("start_clear", 0, 0, 0);
    run(2'd1, '0, 256, 1'b1, 1'b0);
    mism = 0;
    for (int i = 0; i < 256; i++) if (rec[i] !== saved_rand[i]) mism++;
    check("rand_repro_stream", 64'(mism), 64'(0));
    check_counts("rand2", 256, r_es, r_eb);

    // Reset in the middle of a burst.
    mode_i = 2'd2;
    send(1'b1, 1'b1, data[0]);
    guard = 0;
    while (m_left == 0 && guard < 250) begin
      send(1'b1, 1'b0, data[guard]);
      guard++;
    end
    check("mid_burst_mask", 64'(bus.err_mask_o), 64'(2'b11));
    @(negedge clk);
    bus.valid_i = 1'b1;
    bus.sym_i   = data[5];
    #2 rst = 1'b1;
    #1;
    check("rst_mid_out", 64'({bus.valid_o, bus.sym_o, bus.err_mask_o}), 64'(0));
    check_counts("rst_mid", 0, 0, 0);
    check("rst_mid_done", 64'(window_done_o), 64'(0));
    model_clear(1'b1);
    @(negedge clk);
    rst         = 1'b0;
    bus.valid_i = 1'b0;
    run(2'd2, '0, 300, 1'b0, 1'b0);
    check_counts("rst_rerun", 300, b_es, b_eb);
    mism = 0;
    for (int i = 0; i < 300; i++) if (rec[i] !== saved_burst[i]) mism++;
    check("rst_rerun_stream", 64'(mism), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
